// File: rtl/miriscv_uart_tx_if.sv
// Byte write port of the UART transmitter: the producer drives data_i/valid_i and the
// transmitter answers with ready_o; a byte moves on a cycle where valid_i && ready_o.
interface miriscv_uart_tx_if;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;

   modport master (output data_i, output valid_i, input ready_o);
   modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/miriscv_uart_tx.sv
// Buffered UART TX: bytes queue in a FIFO and leave LSB-first as start, 8 data, [even parity
// (MIRISCV_UART_TX_PARITY_EN)], stop; start bit 1 clk after push; ready_o low while FIFO full.
module miriscv_uart_tx #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUDRATE    = 6_250_000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk_i,
   input  logic                          arstn_i,
   miriscv_uart_tx_if.slave              wr,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int LVL_W        = PTR_W + 1;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   generate
      if (CLKS_PER_BIT < 2) begin : g_baud_check
         $error("miriscv_uart_tx: CLKS_PER_BIT must be at least 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
         $error("miriscv_uart_tx: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

`ifdef MIRISCV_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             ready, push, pop, bit_end;
`ifdef MIRISCV_UART_TX_PARITY_EN
   logic             par_q;
`endif

   assign ready        = (level_q != LVL_W'(FIFO_DEPTH));
   assign wr.ready_o   = ready;
   assign push         = wr.valid_i && ready;
   assign bit_end      = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign busy_o       = (state_q != IDLE) || (level_q != '0);
   assign fifo_level_o = level_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (level_q != '0) state_d = START;
         START:  if (bit_end) state_d = DATA;
`ifdef MIRISCV_UART_TX_PARITY_EN
         DATA:   if (bit_end && (bit_idx_q == 3'd7)) state_d = PARITY;
         PARITY: if (bit_end) state_d = STOP;
`else
         DATA:   if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
`endif
         STOP:   if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // tx_o is decoded from the state register so reset forces the line high asynchronously.
   always_comb begin
      tx_o = 1'b1;
      pop  = 1'b0;
      case (state_q)
         IDLE:   pop  = (level_q != '0);
         START:  tx_o = 1'b0;
         DATA:   tx_o = shift_q[0];
`ifdef MIRISCV_UART_TX_PARITY_EN
         PARITY: tx_o = par_q;
`endif
         default: tx_o = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= wr.data_i;
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Baud counter idles at zero so the first START bit gets a full bit period.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         if ((state_q == IDLE) || bit_end) cnt_q <= '0;
         else                              cnt_q <= cnt_q + CNT_W'(1);
         if (pop) begin
            shift_q   <= mem[rd_ptr_q];
            bit_idx_q <= '0;
         end else if ((state_q == DATA) && bit_end) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
         end
      end
   end

`ifdef MIRISCV_UART_TX_PARITY_EN
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i)                        par_q <= 1'b0;
      else if (pop)                        par_q <= 1'b0;
      else if ((state_q == DATA) && bit_end) par_q <= par_q ^ shift_q[0];
   end
`endif
endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Directed bench for miriscv_uart_tx: a queue-based line model checked every cycle, a mid-bit
// receiver monitor, and hand-computed frame literals; follows MIRISCV_UART_TX_PARITY_EN.
module tb_miriscv_uart_tx;
   localparam int CPB   = 16;
   localparam int DEPTH = 8;
`ifdef MIRISCV_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CLKS = NBITS * CPB;

   logic       clk = 1'b0;
   logic       arstn;
   logic       tx, busy;
   logic [3:0] level;
   int         n_checks = 0;
   int         n_fail   = 0;

   miriscv_uart_tx_if wr();

   miriscv_uart_tx #(
      .CLK_FREQ_HZ (100_000_000),
      .BAUDRATE    (6_250_000),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i        (clk),
      .arstn_i      (arstn),
      .wr           (wr),
      .tx_o         (tx),
      .busy_o       (busy),
      .fifo_level_o (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- line model: queue of bytes plus the frame currently on the wire
   logic [7:0]       m_q[$];
   logic [7:0]       sent_log[$];
   logic [7:0]       rx_log[$];
   bit               m_active;
   int               m_t;
   logic [NBITS-1:0] m_bits;

   function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef MIRISCV_UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   initial begin : model
      bit do_push;
      m_active = 1'b0;
      m_t      = 0;
      m_bits   = '1;
      forever begin
         @(posedge clk);
         if (arstn !== 1'b1) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
         end else begin
            do_push = (wr.valid_i === 1'b1) && (m_q.size() != DEPTH);
            if (m_active) begin
               m_t++;
               if (m_t == FRAME_CLKS) m_active = 1'b0;
            end else if (m_q.size() != 0) begin
               m_bits   = frame_of(m_q.pop_front());
               m_active = 1'b1;
               m_t      = 0;
            end
            if (do_push) begin
               m_q.push_back(wr.data_i);
               sent_log.push_back(wr.data_i);
            end
         end
      end
   end

   initial begin : compare
      logic tx_e, busy_e, rdy_e;
      int   lvl_e;
      forever begin
         @(negedge clk);
         if (arstn !== 1'b1) begin
            tx_e = 1'b1; busy_e = 1'b0; rdy_e = 1'b1; lvl_e = 0;
         end else begin
            tx_e   = m_active ? m_bits[m_t / CPB] : 1'b1;
            lvl_e  = m_q.size();
            busy_e = m_active || (lvl_e != 0);
            rdy_e  = (lvl_e != DEPTH);
         end
         chk("cyc_tx",    tx,         tx_e);
         chk("cyc_busy",  busy,       busy_e);
         chk("cyc_level", level,      lvl_e);
         chk("cyc_ready", wr.ready_o, rdy_e);
      end
   end

   // ---------------- receiver sampling mid-bit
   initial begin : monitor
      logic        prev;
      logic [10:0] rb;
      bit          ok;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (arstn === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
            ok = 1'b1;
            rb = '1;
            for (int k = 0; k < NBITS; k++) begin
               for (int c = 0; c < ((k == 0) ? CPB / 2 : CPB); c++) begin
                  @(negedge clk);
                  if (arstn !== 1'b1) ok = 1'b0;
               end
               rb[k] = tx;
            end
            if (ok) begin
               chk("rx_start", rb[0], 0);
               chk("rx_stop", rb[NBITS-1], 1);
`ifdef MIRISCV_UART_TX_PARITY_EN
               chk("rx_parity", rb[9], ^rb[8:1]);
`endif
               rx_log.push_back(rb[8:1]);
            end
         end
         prev = tx;
      end
   end

   // ---------------- stimulus helpers (called at 1 time unit after a rising edge)
   task automatic push(input logic [7:0] b);
      int   n;
      logic accepted;
      n = 0;
      accepted = 1'b0;
      wr.valid_i = 1'b1;
      wr.data_i  = b;
      while (!accepted && n < 5000) begin
         accepted = wr.ready_o;
         @(posedge clk); #1;
         n++;
      end
      if (!accepted) chk("push_accept", accepted, 1);
   endtask

   task automatic idle_bus();
      wr.valid_i = 1'b0;
      wr.data_i  = 8'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_reached", busy, 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_logs(input string tag);
      chk({tag, "_rx_count"}, rx_log.size(), sent_log.size());
      for (int i = 0; i < sent_log.size() && i < rx_log.size(); i++)
         chk($sformatf("%s_rx_byte%0d", tag, i), rx_log[i], sent_log[i]);
      rx_log.delete();
      sent_log.delete();
   endtask

   task automatic literal_frame(input string name, input logic [7:0] b, input logic [10:0] lit);
      int t;
      push(b);
      idle_bus();
      @(posedge clk); #1;
      t = 0;
      chk({name, "_latency_tx"}, tx, 0);
      for (int k = 0; k < NBITS; k++) begin
         while (t < k * CPB + CPB / 2) begin @(posedge clk); #1; t++; end
         chk($sformatf("%s_bit%0d", name, k), tx, lit[k]);
      end
      while (t < FRAME_CLKS - 1) begin @(posedge clk); #1; t++; end
      chk({name, "_busy_last_stop_clk"}, busy, 1);
      @(posedge clk); #1;
      chk({name, "_busy_after_frame"}, busy, 0);
      chk({name, "_tx_after_frame"}, tx, 1);
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [10:0] lit;
      string       s;
      int          lows;
      arstn      = 1'b0;
      wr.valid_i = 1'b0;
      wr.data_i  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", tx, 1);
      chk("reset_ready", wr.ready_o, 1);
      chk("reset_busy", busy, 0);
      chk("reset_level", level, 0);
      #2 arstn = 1'b1;
      @(posedge clk); #1;

      // frame literals in time order: start, data LSB first, [parity], stop
`ifdef MIRISCV_UART_TX_PARITY_EN
      lit = {1'b1, 1'b0, 8'h55, 1'b0};
`else
      lit = {1'b0, 1'b1, 8'h55, 1'b0};
`endif
      literal_frame("t1_0x55", 8'h55, lit);
      wait_idle(100);
      check_logs("t1");

`ifdef MIRISCV_UART_TX_PARITY_EN
      lit = {1'b1, 1'b1, 8'h07, 1'b0};
`else
      lit = {1'b0, 1'b1, 8'h07, 1'b0};
`endif
      literal_frame("t2_0x07", 8'h07, lit);
      wait_idle(100);
      check_logs("t2");

      // 10 bytes held on the port while a frame is already on the line
      push(8'h3C);
      idle_bus();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         push(8'((i * 37 + 5) & 8'hFF));
         if (i == 7) begin
            chk("t3_level_full", level, 8);
            chk("t3_ready_full", wr.ready_o, 0);
         end
      end
      idle_bus();
      wait_idle(4000);
      check_logs("t3");

      // reset during data bit 3 with 4 bytes queued
      push(8'hC3);
      idle_bus();
      @(posedge clk); #1;
      chk("t4_start_tx", tx, 0);
      for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
      idle_bus();
      repeat (4 * CPB + CPB / 2 - 4) @(posedge clk);
      #1;
      chk("t4_level_before_reset", level, 4);
      #2 arstn = 1'b0;
      #1;
      chk("t4_tx_async", tx, 1);
      chk("t4_level_async", level, 0);
      chk("t4_busy_async", busy, 0);
      chk("t4_ready_async", wr.ready_o, 1);
      repeat (3) @(posedge clk);
      #3 arstn = 1'b1;
      sent_log.delete();
      rx_log.delete();
      lows = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if (tx === 1'b0) lows++;
      end
      chk("t4_no_frame_after_reset", lows, 0);
      chk("t4_level_after", level, 0);
      chk("t4_busy_after", busy, 0);
      chk("t4_rx_after", rx_log.size(), 0);
      sent_log.delete();
      rx_log.delete();

      // streamed ASCII string rebuilt by the receiver
      s = "CoreMark test finished\n";
      for (int i = 0; i < s.len(); i++) push(s[i]);
      idle_bus();
      wait_idle(8000);
      chk("t5_rx_len", rx_log.size(), 23);
      for (int i = 0; i < s.len() && i < rx_log.size(); i++)
         chk($sformatf("t5_char%0d", i), rx_log[i], s[i]);
      chk("t5_busy_end", busy, 0);
      rx_log.delete();
      sent_log.delete();

`ifdef MIRISCV_UART_TX_PARITY_EN
      lit = {1'b1, 1'b0, 8'hA3, 1'b0};
`else
      lit = {1'b0, 1'b1, 8'hA3, 1'b0};
`endif
      literal_frame("t6_0xA3", 8'hA3, lit);
      wait_idle(100);
      check_logs("t6");

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
